// File: rtl/pipe_restart_sched_if.sv
//------------------------------------------------------------------------------
// pipe_restart_sched_if
// Request/sequencing bundle between the restart sources and the sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_restart_sched_if #(
    parameter int NSEG = 12
);
    logic            jrestart;
    logic [NSEG-1:0] restartps;
    logic [8:0]      pdepth;
    logic [NSEG-1:0] pip_rst;
    logic [NSEG-1:0] we;
    logic [NSEG-1:0] re;
    logic            busy;
    logic [3:0]      active_seg;
    logic            done_pls;

    modport master (
        output jrestart, restartps, pdepth,
        input  pip_rst, we, re, busy, active_seg, done_pls
    );

    modport slave (
        input  jrestart, restartps, pdepth,
        output pip_rst, we, re, busy, active_seg, done_pls
    );
endinterface

`default_nettype wire

// File: rtl/pipe_restart_sched.sv
//------------------------------------------------------------------------------
// pipe_restart_sched
// Round-robin restart sequencer driving per-segment pipeline FIFO reset/WE/RE.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_restart_sched #(
    parameter int NSEG      = 12,
    parameter int RST_CYC   = 4,
    parameter int RECOV_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    pipe_restart_sched_if.slave      bus
);

    localparam int CMAX = (RST_CYC > RECOV_CYC) ? RST_CYC : RECOV_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RECOV = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [8:0]      fill, fill_nxt;
    logic [3:0]      seg, seg_nxt;
    logic [3:0]      ptr, ptr_nxt;
    logic [NSEG-1:0] pending, pending_nxt;
    logic [NSEG-1:0] pip_rst, pip_rst_nxt;
    logic [NSEG-1:0] we, we_nxt;
    logic [NSEG-1:0] re, re_nxt;
    logic            done, done_nxt;

    logic            found;
    logic [3:0]      gnt_idx;
    logic [4:0]      scan;
    logic [NSEG-1:0] gnt_oh;
    logic [NSEG-1:0] seg_oh;
    logic [NSEG-1:0] req_set;
    logic [NSEG-1:0] grant_clr;

    assign req_set = bus.restartps | {NSEG{bus.jrestart}};
    assign gnt_oh  = NSEG'(1) << gnt_idx;
    assign seg_oh  = NSEG'(1) << seg;

    // First pending segment at or after the pointer, wrapping past NSEG-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < NSEG; i++) begin
            scan = {1'b0, ptr} + 5'(i);
            if (scan >= 5'(NSEG)) begin
                scan = scan - 5'(NSEG);
            end
            if (!found && pending[scan[3:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[3:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fill_nxt    = fill;
        seg_nxt     = seg;
        ptr_nxt     = ptr;
        pip_rst_nxt = pip_rst;
        we_nxt      = we;
        re_nxt      = re;
        done_nxt    = 1'b0;
        grant_clr   = '0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    seg_nxt     = gnt_idx;
                    ptr_nxt     = (gnt_idx == 4'(NSEG - 1)) ? 4'd0 : gnt_idx + 4'd1;
                    grant_clr   = gnt_oh;
                    pip_rst_nxt = pip_rst | gnt_oh;
                    we_nxt      = we & ~gnt_oh;
                    re_nxt      = re & ~gnt_oh;
                    cnt_nxt     = CW'(RST_CYC - 1);
                    state_nxt   = S_RESET;
                end
            end
            S_RESET: begin
                if (cnt == '0) begin
                    pip_rst_nxt = pip_rst & ~seg_oh;
                    cnt_nxt     = CW'(RECOV_CYC - 1);
                    state_nxt   = S_RECOV;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_RECOV: begin
                if (cnt == '0) begin
                    we_nxt = we | seg_oh;
                    // A zero-depth fill releases reads on the same edge as writes.
                    if (bus.pdepth == 9'd0) begin
                        re_nxt    = re | seg_oh;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        fill_nxt  = bus.pdepth;
                        state_nxt = S_FILL;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_FILL: begin
                fill_nxt = fill - 9'd1;
                if (fill == 9'd1) begin
                    re_nxt    = re | seg_oh;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A request on the grant edge wins over the clear and re-queues.
        pending_nxt = (pending & ~grant_clr) | req_set;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fill    <= '0;
            seg     <= '0;
            ptr     <= '0;
            pending <= '0;
            pip_rst <= '0;
            we      <= '0;
            re      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            fill    <= fill_nxt;
            seg     <= seg_nxt;
            ptr     <= ptr_nxt;
            pending <= pending_nxt;
            pip_rst <= pip_rst_nxt;
            we      <= we_nxt;
            re      <= re_nxt;
            done    <= done_nxt;
        end
    end

    assign bus.pip_rst    = pip_rst;
    assign bus.we         = we;
    assign bus.re         = re;
    assign bus.busy       = (state != S_IDLE);
    assign bus.active_seg = seg;
    assign bus.done_pls   = done;

endmodule

`default_nettype wire

// File: tb/tb_pipe_restart_sched.sv
//------------------------------------------------------------------------------
// tb_pipe_restart_sched
// Directed timing scenarios plus randomized traffic against a timeline model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_restart_sched;

    localparam int NSEG  = 12;
    localparam int RSTC  = 4;
    localparam int RECC  = 8;

    logic clk;
    logic rst_b;
    int   total;
    int   bad;

    pipe_restart_sched_if #(.NSEG(NSEG)) bus ();

    pipe_restart_sched #(
        .NSEG      (NSEG),
        .RST_CYC   (RSTC),
        .RECOV_CYC (RECC)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: a grant at edge g fixes every later event time.
    int              m_t, m_g, m_end, m_k;
    logic [NSEG-1:0] m_pend, m_pip, m_we, m_re, m_set, m_clr;
    logic            m_busy, m_done;
    logic [3:0]      m_seg, m_ptr;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_pend = '0; m_pip = '0; m_we = '0; m_re = '0;
            m_busy = 1'b0; m_done = 1'b0; m_seg = '0; m_ptr = '0;
            m_g = 0; m_end = 0;
        end else begin
            m_set  = bus.restartps | {NSEG{bus.jrestart}};
            m_clr  = '0;
            m_done = 1'b0;
            if (m_busy) begin
                if (m_t - m_g == RSTC) m_pip[m_seg] = 1'b0;
                if (m_t - m_g == RSTC + RECC) begin
                    m_we[m_seg] = 1'b1;
                    m_end = m_g + RSTC + RECC + int'(bus.pdepth);
                end
                if (m_t - m_g >= RSTC + RECC && m_t == m_end) begin
                    m_re[m_seg] = 1'b1;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (m_pend != '0) begin
                for (int i = 0; i < NSEG; i++) begin
                    m_k = (int'(m_ptr) + i) % NSEG;
                    if (!m_busy && m_pend[m_k]) begin
                        m_busy = 1'b1;
                        m_seg  = 4'(m_k);
                        m_ptr  = 4'((m_k + 1) % NSEG);
                        m_g    = m_t;
                        m_clr[m_k] = 1'b1;
                        m_pip[m_k] = 1'b1;
                        m_we[m_k]  = 1'b0;
                        m_re[m_k]  = 1'b0;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_set;
        end
        m_t = m_t + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_b         = 1'b0;
        bus.jrestart  = 1'b0;
        bus.restartps = '0;
        bus.pdepth    = 9'd10;
        repeat (3) tick();
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg, bus.done_pls} !== '0) begin
            bad++;
            $display("FAIL reset_state got pip=%h we=%h re=%h busy=%b seg=%0d done=%b required all zero",
                     bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg, bus.done_pls);
        end
    endtask

    task automatic test_single();
        logic [4:0] got, exp;
        apply_reset();
        bus.restartps = 12'h008;
        tick();
        bus.restartps = '0;
        for (int n = 1; n <= 25; n++) begin
            tick();
            exp = {(n >= 1 && n <= 4), (n >= 13), (n >= 23), (n >= 1 && n < 23), (n == 23)};
            got = {bus.pip_rst[3], bus.we[3], bus.re[3], bus.busy, bus.done_pls};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL single edge=%0d got pip/we/re/busy/done=%b required %b", n, got, exp);
            end
        end
        total++;
        if (bus.active_seg !== 4'd3) begin
            bad++;
            $display("FAIL single_active_seg got %0d required 3", bus.active_seg);
        end
    endtask

    task automatic test_jrestart();
        logic [NSEG-1:0] e_pip, e_we, e_re;
        apply_reset();
        bus.jrestart = 1'b1;
        tick();
        bus.jrestart = 1'b0;
        for (int n = 1; n <= 280; n++) begin
            tick();
            e_pip = '0; e_we = '0; e_re = '0;
            for (int j = 0; j < NSEG; j++) begin
                e_pip[j] = (n >= 23 * j + 1) && (n <= 23 * j + 4);
                e_we[j]  = (n >= 23 * j + 13);
                e_re[j]  = (n >= 23 * j + 23);
            end
            total++;
            if ({bus.pip_rst, bus.we, bus.re} !== {e_pip, e_we, e_re} || $countones(bus.pip_rst) > 1) begin
                bad++;
                $display("FAIL jrestart edge=%0d got pip=%h we=%h re=%h required pip=%h we=%h re=%h",
                         n, bus.pip_rst, bus.we, bus.re, e_pip, e_we, e_re);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.restartps = 12'h020;
        tick();
        bus.restartps = '0;
        repeat (23) tick();
        bus.restartps = 12'h084;
        tick();
        bus.restartps = '0;
        tick();
        total++;
        if (bus.active_seg !== 4'd7 || bus.pip_rst !== 12'h080) begin
            bad++;
            $display("FAIL rr_first got seg=%0d pip=%h required seg=7 pip=080", bus.active_seg, bus.pip_rst);
        end
        repeat (23) tick();
        total++;
        if (bus.active_seg !== 4'd2 || bus.pip_rst !== 12'h004) begin
            bad++;
            $display("FAIL rr_second got seg=%0d pip=%h required seg=2 pip=004", bus.active_seg, bus.pip_rst);
        end
    endtask

    task automatic test_zero_depth();
        logic [3:0] got, exp;
        apply_reset();
        bus.pdepth    = 9'd0;
        bus.restartps = 12'h001;
        tick();
        bus.restartps = '0;
        for (int n = 1; n <= 15; n++) begin
            tick();
            exp = {(n >= 13), (n >= 13), (n >= 1 && n < 13), (n == 13)};
            got = {bus.we[0], bus.re[0], bus.busy, bus.done_pls};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL zero_depth edge=%0d got we/re/busy/done=%b required %b", n, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, exp;
        apply_reset();
        bus.restartps = 12'h010;
        tick();
        bus.restartps = '0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) bus.restartps = 12'h010;
            tick();
            bus.restartps = '0;
            exp = {((n >= 1 && n <= 4) || (n >= 24 && n <= 27)), (n >= 13 && n < 24), (n == 23),
                   (n != 23), (n == 23)};
            got = {bus.pip_rst[4], bus.we[4], bus.re[4], bus.busy, bus.done_pls};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rerequest edge=%0d got pip/we/re/busy/done=%b required %b", n, got, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        bus.restartps = 12'h008;
        tick();
        bus.restartps = '0;
        repeat (15) tick();
        rst_b = 1'b0;
        #1;
        total++;
        if ({bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg, bus.done_pls} !== '0) begin
            bad++;
            $display("FAIL mid_reset got pip=%h we=%h re=%h busy=%b seg=%0d required all zero",
                     bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg);
        end
        tick();
        rst_b = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if ({bus.pip_rst, bus.we, bus.re, bus.busy, bus.done_pls} !== '0) begin
                bad++;
                $display("FAIL post_reset_idle cycle=%0d got pip=%h we=%h re=%h busy=%b required all zero",
                         n, bus.pip_rst, bus.we, bus.re, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.restartps = ($urandom_range(0, 19) == 0) ? (12'($urandom) & 12'($urandom)) : '0;
            bus.jrestart  = ($urandom_range(0, 399) == 0);
            bus.pdepth    = 9'($urandom_range(0, 12));
            rst_b         = !(n == 1500);
            tick();
            total++;
            if ({bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg, bus.done_pls} !==
                {m_pip, m_we, m_re, m_busy, m_seg, m_done}) begin
                bad++;
                $display("FAIL random cycle=%0d got pip=%h we=%h re=%h busy=%b seg=%0d done=%b required pip=%h we=%h re=%h busy=%b seg=%0d done=%b",
                         n, bus.pip_rst, bus.we, bus.re, bus.busy, bus.active_seg, bus.done_pls,
                         m_pip, m_we, m_re, m_busy, m_seg, m_done);
            end
        end
        rst_b = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        m_t           = 0;
        rst_b         = 1'b1;
        bus.jrestart  = 1'b0;
        bus.restartps = '0;
        bus.pdepth    = 9'd10;
        test_reset();
        test_single();
        test_jrestart();
        test_round_robin();
        test_zero_depth();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_restart_sched.md
# pipe_restart_sched

Shared restart sequencer for the twelve DAQ pipeline segments (6 groups × 2 segments). It collects restart requests from the JTAG restart command and from the per-segment DSR restart pulses, and grants them one segment at a time in round-robin order. For each granted segment it runs the full pipeline start-up: FIFO reset, reset recovery, a write-only fill of PDEPTH cycles, then read enable. It drives the per-segment PIP_RST/WE/RE lines that feed the pipeline FIFOs in place of per-segment start FSMs, so no two segment FIFOs come out of reset in the same window.

## Interface
- NSEG, 12: number of pipeline segments; bit i = group (i/2)+1, segment i%2
- RST_CYC, 4: cycles PIP_RST is held high per segment
- RECOV_CYC, 8: cycles after PIP_RST falls before WE rises (FIFO reset recovery)
- CLK  in  1  write/sequencer clock, all logic on rising edge
- RST_B  in  1  asynchronous, active-low reset
- JRESTART  in  1  restart request for all segments, level-sampled each edge
- RESTARTPS  in  NSEG  per-segment restart request, level-sampled each edge
- PDEPTH  in  9  pipeline depth in cycles, sampled on entry to FILL
- PIP_RST  out  NSEG  per-segment pipeline FIFO reset, active high
- WE  out  NSEG  per-segment FIFO write enable
- RE  out  NSEG  per-segment FIFO read enable
- BUSY  out  1  high while a segment is in RESET, RECOV or FILL
- ACTIVE_SEG  out  4  index of the segment being sequenced; holds the last value when idle
- DONE_PLS  out  1  one-cycle pulse when a segment reaches RUN

## Operation
- Async reset (RST_B low) clears all state: PIP_RST, WE and RE are all 0; BUSY=0; ACTIVE_SEG=0; DONE_PLS=0; pending mask=0; round-robin pointer=0; state=IDLE. After reset, every segment is stopped until it is requested.
- Pending mask: on each edge, pending[i] is set if RESTARTPS[i] or JRESTART is high. pending[i] is cleared on the edge that grants segment i. Set has priority over clear on the same edge, so a request during the grant edge re-queues the segment.
- Arbiter, in IDLE: if any pending bit is set, grant the first pending index found scanning upward (with wrap) from the pointer. Set ACTIVE_SEG to that index, set the pointer to index+1 mod NSEG, and go to RESET.
- RESET (RST_CYC cycles):
  - PIP_RST[s]=1, WE[s]=0, RE[s]=0.
  - WE/RE of every other segment are unchanged; running segments keep running.
- RECOV (RECOV_CYC cycles): PIP_RST[s]=0, WE[s]=0, RE[s]=0.
- FILL:
  - On entry, latch D=PDEPTH. WE[s]=1.
  - A 9-bit down-counter loaded with D; leave FILL when the counter reaches 0.
  - D=0 means FILL lasts 0 cycles: WE[s] and RE[s] rise on the same edge.
- RUN transition: RE[s]=1 and DONE_PLS=1 for one cycle, then return to IDLE. WE[s] and RE[s] stay 1 until segment s is granted again.
- PDEPTH changes after FILL entry have no effect on the current fill.
- Requests arriving while BUSY are only queued; the current sequence is never aborted. A request for the active segment re-runs it after the current sequence.
- JRESTART restarts all segments in order from the pointer.

## Timing
- Request high at edge k sets pending at edge k. Grant happens at edge k+1 if IDLE.
- Grant at edge g:
  - PIP_RST[s] is high after edges g … g+RST_CYC−1.
  - WE[s] rises after edge g+RST_CYC+RECOV_CYC.
  - RE[s] and DONE_PLS rise after edge g+RST_CYC+RECOV_CYC+D.
  - BUSY is high from edge g until the RE edge.
- The earliest next grant is one edge after the RE edge. The sequence period is 1+RST_CYC+RECOV_CYC+D cycles.
- Counters are unsigned. RST_CYC and RECOV_CYC counters are sized by clog2 and never wrap.
- Reset asserted mid-sequence clears everything immediately; the in-progress segment is not resumed.

## Test plan
- Single request (RST_CYC=4, RECOV_CYC=8, PDEPTH=10), RESTARTPS[3] pulsed at edge 0:
  - PIP_RST[3] high edges 1–4; WE[3] rises at edge 13; RE[3] and DONE_PLS at edge 23.
  - BUSY falls at edge 23; ACTIVE_SEG=3.
- JRESTART one-cycle pulse at edge 0, PDEPTH=10:
  - Segments are granted 0..11 in order; RE[j] rises at edge 23+23j, so RE[11] rises at edge 276.
  - No two PIP_RST bits are ever high together.
- Round-robin: after seg 5 completes, RESTARTPS[2] and RESTARTPS[7] are raised together → seg 7 is granted first, then seg 2.
- PDEPTH=0, RESTARTPS[0] at edge 0: WE[0] and RE[0] rise together at edge 13; DONE_PLS at edge 13.
- Re-request during the active sequence: RESTARTPS[4] pulsed at edge 5 while seg 4 is in RESET → seg 4 completes at edge 23, is re-granted at edge 24, and WE[4]/RE[4] drop during the second RESET.
- RST_B low at edge 15 mid-FILL → all outputs 0 immediately; after release with no requests, the block stays IDLE with BUSY=0.
